ysyx_22040127_decode: RTL and testbench



---
 rtl/ysyx_22040127_decode_if.sv | 30 +++
 rtl/ysyx_22040127_decode.sv | 127 ++++++++++++
 tb/tb_ysyx_22040127_decode.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040127_decode_if.sv
// Fetch-to-decode, decode-to-execute and writeback signals of the decode stage.
// The decode stage is the slave; the fetch/execute/writeback side is the master.
interface ysyx_22040127_decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [63:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst_out;
  logic [63:0] src0;
  logic [63:0] src1;
  logic [63:0] imm;
  logic [63:0] store_data;
  logic [2:0]  inst_type;
  logic [4:0]  rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  modport slave (
    input  in_valid, instruction, pc, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, inst_out, src0, src1, imm, store_data, inst_type, rd
  );

  modport master (
    output in_valid, instruction, pc, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, inst_out, src0, src1, imm, store_data, inst_type, rd
  );
endinterface

// File: rtl/ysyx_22040127_decode.sv
// RV64I decode/operand-fetch stage with a single-entry output register and the 32x64 register file.
// Optional feature: YSYX_22040127_BYPASS_EN forwards a same-edge writeback into the captured operands.
module ysyx_22040127_decode (
   input logic                       clk,
   input logic                       rst,
   ysyx_22040127_decode_if.slave     bus
);

   localparam logic [2:0] TY_I = 3'd0, TY_U = 3'd1, TY_S = 3'd2, TY_J = 3'd3,
                          TY_R = 3'd4, TY_B = 3'd5, TY_X = 3'd7;

   logic [63:0] r_rf [32];
   logic        r_out_valid;
   logic [31:0] r_inst;
   logic [63:0] r_src0, r_src1, r_imm, r_sd;
   logic [2:0]  r_type;
   logic [4:0]  r_rd;

   logic [31:0] w_in;
   logic [6:0]  w_op;
   logic [4:0]  w_rs1, w_rs2;
   logic [2:0]  w_type;
   logic [63:0] w_imm, w_x1, w_x2, w_src0, w_src1, w_sd;
   logic [4:0]  w_rd;
   logic        w_cap;

   assign w_in  = bus.instruction;
   assign w_op  = w_in[6:0];
   assign w_rs1 = w_in[19:15];
   assign w_rs2 = w_in[24:20];
   assign w_cap = bus.in_valid && bus.in_ready;

`ifdef YSYX_22040127_BYPASS_EN
   assign w_x1 = (w_rs1 == 5'd0) ? 64'd0 :
                 (bus.wb_en && bus.wb_rd == w_rs1) ? bus.wb_data : r_rf[w_rs1];
   assign w_x2 = (w_rs2 == 5'd0) ? 64'd0 :
                 (bus.wb_en && bus.wb_rd == w_rs2) ? bus.wb_data : r_rf[w_rs2];
`else
   assign w_x1 = (w_rs1 == 5'd0) ? 64'd0 : r_rf[w_rs1];
   assign w_x2 = (w_rs2 == 5'd0) ? 64'd0 : r_rf[w_rs2];
`endif

   always_comb begin
      w_type = TY_X;
      case (w_op)
         7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b1110011: w_type = TY_I;
         7'b0110111, 7'b0010111: w_type = TY_U;
         7'b0100011:             w_type = TY_S;
         7'b1101111:             w_type = TY_J;
         7'b0110011, 7'b0111011: w_type = TY_R;
         7'b1100011:             w_type = TY_B;
         default:                w_type = TY_X;
      endcase
   end

   always_comb begin
      w_imm = 64'd0;
      case (w_type)
         TY_I: w_imm = {{52{w_in[31]}}, w_in[31:20]};
         TY_S: w_imm = {{52{w_in[31]}}, w_in[31:25], w_in[11:7]};
         TY_B: w_imm = {{51{w_in[31]}}, w_in[31], w_in[7], w_in[30:25], w_in[11:8], 1'b0};
         TY_U: w_imm = {{32{w_in[31]}}, w_in[31:12], 12'd0};
         TY_J: w_imm = {{43{w_in[31]}}, w_in[31], w_in[19:12], w_in[20], w_in[30:21], 1'b0};
         default: w_imm = 64'd0;
      endcase
   end

   // LUI and AUIPC share the U type; only AUIPC takes pc as its base.
   always_comb begin
      w_src0 = 64'd0;
      w_src1 = 64'd0;
      w_sd   = 64'd0;
      w_rd   = w_in[11:7];
      case (w_type)
         TY_I:       begin w_src0 = w_x1; w_src1 = w_imm; end
         TY_S:       begin w_src0 = w_x1; w_src1 = w_imm; w_sd = w_x2; w_rd = 5'd0; end
         TY_B:       begin w_src0 = w_x1; w_src1 = w_x2; w_rd = 5'd0; end
         TY_R:       begin w_src0 = w_x1; w_src1 = w_x2; end
         TY_U:       begin w_src0 = (w_op == 7'b0010111) ? bus.pc : 64'd0; w_src1 = w_imm; end
         TY_J:       begin w_src0 = bus.pc; w_src1 = w_imm; end
         default:    w_rd = 5'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) r_rf[i] <= 64'd0;
      end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
         r_rf[bus.wb_rd] <= bus.wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_inst      <= 32'd0;
         r_src0      <= 64'd0;
         r_src1      <= 64'd0;
         r_imm       <= 64'd0;
         r_sd        <= 64'd0;
         r_type      <= 3'd0;
         r_rd        <= 5'd0;
      end else if (w_cap) begin
         r_out_valid <= 1'b1;
         r_inst      <= w_in;
         r_src0      <= w_src0;
         r_src1      <= w_src1;
         r_imm       <= w_imm;
         r_sd        <= w_sd;
         r_type      <= w_type;
         r_rd        <= w_rd;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready   = !r_out_valid || bus.out_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.inst_out   = r_inst;
   assign bus.src0       = r_src0;
   assign bus.src1       = r_src1;
   assign bus.imm        = r_imm;
   assign bus.store_data = r_sd;
   assign bus.inst_type  = r_type;
   assign bus.rd         = r_rd;

endmodule

// File: tb/tb_ysyx_22040127_decode.sv
// Scoreboard bench for the decode stage: directed instructions push expected results,
// a negedge monitor pops and compares each consumed output.
module tb_ysyx_22040127_decode;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ysyx_22040127_decode_if bus();
   ysyx_22040127_decode dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [31:0] inst;
      logic [63:0] s0, s1, imm, sd;
      logic [2:0]  ty;
      logic [4:0]  rd;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

`ifdef YSYX_22040127_BYPASS_EN
   localparam logic [63:0] SD_BYP = 64'hAA;
`else
   localparam logic [63:0] SD_BYP = 64'h0;
`endif

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] inst, input logic [63:0] s0, input logic [63:0] s1,
                               input logic [63:0] imm, input logic [63:0] sd, input logic [2:0] ty,
                               input logic [4:0] rd);
      exp_t e;
      e.inst = inst; e.s0 = s0; e.s1 = s1; e.imm = imm; e.sd = sd; e.ty = ty; e.rd = rd;
      return e;
   endfunction

   // Monitor: every consumed output must match the oldest pending expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got inst %h expected none", bus.inst_out);
         end else begin
            e = q.pop_front();
            chk("inst_out",   {32'd0, bus.inst_out}, {32'd0, e.inst});
            chk("src0",       bus.src0, e.s0);
            chk("src1",       bus.src1, e.s1);
            chk("imm",        bus.imm, e.imm);
            chk("store_data", bus.store_data, e.sd);
            chk("inst_type",  {61'd0, bus.inst_type}, {61'd0, e.ty});
            chk("rd",         {59'd0, bus.rd}, {59'd0, e.rd});
         end
      end
   end

   task automatic issue(input logic [31:0] ins, input logic [63:0] p, input exp_t e, input bit push);
      int n = 0;
      bus.in_valid = 1'b1; bus.instruction = ins; bus.pc = p;
      @(negedge clk);
      while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
      if (!bus.in_ready) begin
         checks++; errors++;
         $display("FAIL issue_timeout: got in_ready 0 expected 1 for inst %h", ins);
      end else if (push) q.push_back(e);
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.wb_en = 1'b0;
   endtask

   task automatic wb(input logic [4:0] r, input logic [63:0] d);
      bus.wb_en = 1'b1; bus.wb_rd = r; bus.wb_data = d;
      @(posedge clk); #1;
      bus.wb_en = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b0;
      bus.in_valid = 1'b0; bus.instruction = 32'd0; bus.pc = 64'd0; bus.out_ready = 1'b1;
      bus.wb_en = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 64'd0;
      #12;
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_in_ready",  {63'd0, bus.in_ready}, 64'd1);
      chk("rst_src0",      bus.src0, 64'd0);
      chk("rst_src1",      bus.src1, 64'd0);
      chk("rst_imm",       bus.imm, 64'd0);
      chk("rst_store",     bus.store_data, 64'd0);
      chk("rst_inst",      {32'd0, bus.inst_out}, 64'd0);
      chk("rst_type",      {61'd0, bus.inst_type}, 64'd0);
      chk("rst_rd",        {59'd0, bus.rd}, 64'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      issue(32'hFFB00093, 64'h0, mk(32'hFFB00093, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB,
            64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 3'd0, 5'd1), 1'b1);
      wb(5'd1, 64'd7);
      wb(5'd2, 64'h1234);
      issue(32'h002081B3, 64'h0, mk(32'h002081B3, 64'd7, 64'h1234, 64'd0, 64'd0, 3'd4, 5'd3), 1'b1);
      issue(32'h80000297, 64'h8000_0000, mk(32'h80000297, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000,
            64'hFFFF_FFFF_8000_0000, 64'd0, 3'd1, 5'd5), 1'b1);
      issue(32'h123453B7, 64'h4, mk(32'h123453B7, 64'd0, 64'h1234_5000, 64'h1234_5000,
            64'd0, 3'd1, 5'd7), 1'b1);
      @(posedge clk); #1;

      // Backpressure: jal held while beq waits, then both swap on one edge.
      bus.out_ready = 1'b0;
      issue(32'h008000EF, 64'h100, mk(32'h008000EF, 64'h100, 64'd8, 64'd8, 64'd0, 3'd3, 5'd1), 1'b1);
      bus.in_valid = 1'b1; bus.instruction = 32'hFE208EE3; bus.pc = 64'h104;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_in_ready",  {63'd0, bus.in_ready}, 64'd0);
         chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
         chk("bp_src0",      bus.src0, 64'h100);
         chk("bp_imm",       bus.imm, 64'd8);
         chk("bp_inst",      {32'd0, bus.inst_out}, 64'h008000EF);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      issue(32'hFE208EE3, 64'h104, mk(32'hFE208EE3, 64'd7, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFC,
            64'd0, 3'd5, 5'd0), 1'b1);

      // Writeback to x4 on the same edge as the sd capture.
      bus.wb_en = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 64'hAA;
      issue(32'h0040B023, 64'h0, mk(32'h0040B023, 64'd7, 64'd0, 64'd0, SD_BYP, 3'd2, 5'd0), 1'b1);
      issue(32'h00020433, 64'h0, mk(32'h00020433, 64'hAA, 64'd0, 64'd0, 64'd0, 3'd4, 5'd8), 1'b1);
      wb(5'd0, 64'hFF);
      issue(32'h00000333, 64'h0, mk(32'h00000333, 64'd0, 64'd0, 64'd0, 64'd0, 3'd4, 5'd6), 1'b1);
      issue(32'h0000007F, 64'h55, mk(32'h0000007F, 64'd0, 64'd0, 64'd0, 64'd0, 3'd7, 5'd0), 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;

      // Reset while an instruction is held: output and register file must clear.
      bus.out_ready = 1'b0;
      issue(32'hFFB00093, 64'h0, mk(32'h0, 64'd0, 64'd0, 64'd0, 64'd0, 3'd0, 5'd0), 1'b0);
      chk("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("mid_rst_src1",      bus.src1, 64'd0);
      chk("mid_rst_imm",       bus.imm, 64'd0);
      chk("mid_rst_inst",      {32'd0, bus.inst_out}, 64'd0);
      chk("mid_rst_rd",        {59'd0, bus.rd}, 64'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      issue(32'h002081B3, 64'h0, mk(32'h002081B3, 64'd0, 64'd0, 64'd0, 64'd0, 3'd4, 5'd3), 1'b1);

      n = 0;
      while (q.size() != 0 && n < 20) begin @(posedge clk); n++; end
      #1;
      if (q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
